// File: rtl/shot_tracker_pkg.sv
// Shared battleship definitions: map geometry, shot result codes, attack FSM encodings.
package shot_tracker_pkg;

  localparam int unsigned MAP_COLS = 5;
  localparam int unsigned MAP_ROWS = 7;
  localparam int unsigned MAP_BITS = 35;

  localparam logic [2:0] ResNone    = 3'd0;
  localparam logic [2:0] ResMiss    = 3'd1;
  localparam logic [2:0] ResHit     = 3'd2;
  localparam logic [2:0] ResRepeat  = 3'd3;
  localparam logic [2:0] ResInvalid = 3'd4;

  localparam logic [2:0] StIdle        = 3'd0;
  localparam logic [2:0] StReady       = 3'd1;
  localparam logic [2:0] StEval        = 3'd2;
  localparam logic [2:0] StWaitRelease = 3'd3;
  localparam logic [2:0] StDone        = 3'd4;

  // Column-major cell index; column x occupies bits [x*7+6:x*7].
  function automatic logic [5:0] idx(input logic [2:0] x, input logic [2:0] y);
    return 6'(x) * 6'd7 + 6'(y);
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a counter debouncer; emits the stable level and a rise pulse.
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            rise_q, rise_d;

  // The counter only runs while the synced sample disagrees with the current level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync_q[1];
        rise_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], button};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/shot_tracker.sv
// Attack-phase engine: commits one debounced shot per press, tracks maps, budget, win/loss, display.
module shot_tracker
  import shot_tracker_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20,
  parameter int unsigned MAX_SHOTS       = 15,
  parameter int unsigned BLINK_CYCLES    = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [MAP_BITS-1:0] selected_map,
  input  logic [2:0]          x_coord_code,
  input  logic [2:0]          y_coord_code,
  input  logic                confirmAttack,
  output logic [MAP_BITS-1:0] matriz_data,
  output logic [MAP_BITS-1:0] hit_map,
  output logic [MAP_BITS-1:0] shot_map,
  output logic [2:0]          last_result,
  output logic [3:0]          shots_left,
  output logic                game_over,
  output logic                player_won
);

  localparam int unsigned BlinkW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic                level, press;
  logic [2:0]          state_q, state_d;
  logic [2:0]          x_q, x_d, y_q, y_d;
  logic [MAP_BITS-1:0] hit_q, hit_d, shot_q, shot_d;
  logic [2:0]          result_q, result_d;
  logic [3:0]          shots_q, shots_d;
  logic                won_q, won_d;
  logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
  logic                blink_q, blink_d;
  logic [MAP_BITS-1:0] cell_mask, hit_upd;
  logic                coord_valid;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_confirm_db (
    .clk   (clk),
    .rst   (rst),
    .button(confirmAttack),
    .level (level),
    .rise  (press)
  );

  assign cell_mask   = MAP_BITS'(1) << idx(x_q, y_q);
  assign hit_upd     = hit_q | (cell_mask & selected_map);
  assign coord_valid = (x_q < 3'(MAP_COLS)) && (y_q < 3'(MAP_ROWS));

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    hit_d       = hit_q;
    shot_d      = shot_q;
    result_d    = result_q;
    shots_d     = shots_q;
    won_d       = won_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = blink_q;

    if (blink_cnt_q == BlinkW'(BLINK_CYCLES - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BlinkW'(1);
    end

    case (state_q)
      StIdle: state_d = StReady;
      StReady: begin
        if (press) begin
          x_d     = x_coord_code;
          y_d     = y_coord_code;
          state_d = StEval;
        end
      end
      StEval: begin
        if (!coord_valid) begin
          result_d = ResInvalid;
          state_d  = StWaitRelease;
        end else if ((shot_q & cell_mask) != '0) begin
          result_d = ResRepeat;
          state_d  = StWaitRelease;
        end else begin
          shot_d   = shot_q | cell_mask;
          hit_d    = hit_upd;
          result_d = ((selected_map & cell_mask) != '0) ? ResHit : ResMiss;
          if (shots_q != 4'd0) shots_d = shots_q - 4'd1;
          // Win takes precedence over running out on the final shot.
          if ((selected_map & ~hit_upd) == '0) begin
            won_d   = 1'b1;
            state_d = StDone;
          end else if (shots_d == 4'd0) begin
            state_d = StDone;
          end else begin
            state_d = StWaitRelease;
          end
        end
      end
      StWaitRelease: if (!level) state_d = StReady;
      StDone: ;
      default: state_d = StIdle;
    endcase

    if (!enable) begin
      state_d     = StIdle;
      x_d         = '0;
      y_d         = '0;
      hit_d       = '0;
      shot_d      = '0;
      result_d    = ResNone;
      shots_d     = 4'(MAX_SHOTS);
      won_d       = 1'b0;
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      hit_q       <= '0;
      shot_q      <= '0;
      result_q    <= ResNone;
      shots_q     <= 4'(MAX_SHOTS);
      won_q       <= 1'b0;
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      hit_q       <= hit_d;
      shot_q      <= shot_d;
      result_q    <= result_d;
      shots_q     <= shots_d;
      won_q       <= won_d;
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  always_comb begin
    case (state_q)
      StIdle: matriz_data = '0;
      StDone: matriz_data = won_q ? selected_map
                                  : (hit_q | (selected_map & {MAP_BITS{blink_q}}));
      default: matriz_data = hit_q | ((shot_q & ~hit_q) & {MAP_BITS{blink_q}});
    endcase
  end

  assign hit_map     = hit_q;
  assign shot_map    = shot_q;
  assign last_result = result_q;
  assign shots_left  = shots_q;
  assign game_over   = (state_q == StDone);
  assign player_won  = won_q;

endmodule
